// File: rtl/fir_coef_loader.sv
// rtl/fir_coef_loader.sv - framed byte-stream loader that commits checked coefficient blocks to the FIR tap memory
module fir_coef_loader #(
    parameter int NTAPS   = 64,
    parameter int AW      = 6,
    parameter int CW      = 17,
    parameter int TIMEOUT = 1023
) (
    input  logic          clk_fast,
    input  logic          rst_n,
    input  logic [7:0]    s_data,
    input  logic          s_valid,
    output logic          s_ready,
    output logic [CW-1:0] cin,
    output logic [AW-1:0] caddr,
    output logic          cload,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [1:0]    err_code
);
    localparam int            TW     = $clog2(TIMEOUT + 1);
    localparam logic [8:0]    NTAPS9 = 9'(NTAPS);
    localparam logic [TW-1:0] TLAST  = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] TONE   = TW'(1);
    localparam logic [AW:0]   IONE   = (AW+1)'(1);
    localparam logic [AW-1:0] AONE   = AW'(1);
    localparam logic [7:0]    HDR    = 8'hA5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_COUNT,
        S_ADDR,
        S_DATA,
        S_CSUM,
        S_COMMIT
    } state_t;

    state_t        state;
    logic [AW:0]   n_cnt;
    logic [AW-1:0] a_base;
    logic [AW:0]   idx;
    logic [1:0]    bidx;
    logic [7:0]    b0;
    logic [7:0]    b1;
    logic [7:0]    csum;
    logic [TW-1:0] tcnt;
    logic [CW-1:0] shadow [NTAPS];

    logic          accept;
    logic          shadow_we;
    logic [AW:0]   idx_last;
    logic [AW-1:0] ridx;
    logic [8:0]    end_addr;
    logic [CW-1:0] coef;

    assign accept    = s_valid & s_ready;
    assign shadow_we = accept && (state == S_DATA) && (bidx == 2'd2);
    assign idx_last  = n_cnt - IONE;
    assign ridx      = idx[AW-1:0] + AONE;
    assign end_addr  = {1'b0, s_data} + {{(8-AW){1'b0}}, n_cnt};
    assign coef      = CW'({s_data[0], b1, b0});

    // Shadow buffer holds the frame until the checksum clears; never reset.
    always_ff @(posedge clk_fast) begin
        if (shadow_we) begin
            shadow[idx[AW-1:0]] <= coef;
        end
    end

    always_ff @(posedge clk_fast or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            s_ready  <= 1'b1;
            cin      <= '0;
            caddr    <= '0;
            cload    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            err_code <= 2'd0;
            n_cnt    <= '0;
            a_base   <= '0;
            idx      <= '0;
            bidx     <= 2'd0;
            b0       <= 8'd0;
            b1       <= 8'd0;
            csum     <= 8'd0;
            tcnt     <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept && s_data == HDR) begin
                        state <= S_COUNT;
                        busy  <= 1'b1;
                        tcnt  <= '0;
                    end
                end
                S_COMMIT: begin
                    if (idx == idx_last) begin
                        state   <= S_IDLE;
                        cload   <= 1'b0;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        s_ready <= 1'b1;
                    end else begin
                        idx   <= idx + IONE;
                        caddr <= caddr + AONE;
                        cin   <= shadow[ridx];
                    end
                end
                default: begin
                    if (accept) begin
                        tcnt <= '0;
                        case (state)
                            S_COUNT: begin
                                if (s_data == 8'd0 || {1'b0, s_data} > NTAPS9) begin
                                    state    <= S_IDLE;
                                    busy     <= 1'b0;
                                    err      <= 1'b1;
                                    err_code <= 2'd1;
                                end else begin
                                    n_cnt <= s_data[AW:0];
                                    csum  <= s_data;
                                    state <= S_ADDR;
                                end
                            end
                            S_ADDR: begin
                                if (end_addr > NTAPS9) begin
                                    state    <= S_IDLE;
                                    busy     <= 1'b0;
                                    err      <= 1'b1;
                                    err_code <= 2'd1;
                                end else begin
                                    a_base <= s_data[AW-1:0];
                                    csum   <= csum ^ s_data;
                                    idx    <= '0;
                                    bidx   <= 2'd0;
                                    state  <= S_DATA;
                                end
                            end
                            S_DATA: begin
                                csum <= csum ^ s_data;
                                case (bidx)
                                    2'd0: begin
                                        b0   <= s_data;
                                        bidx <= 2'd1;
                                    end
                                    2'd1: begin
                                        b1   <= s_data;
                                        bidx <= 2'd2;
                                    end
                                    default: begin
                                        bidx <= 2'd0;
                                        if (idx == idx_last) begin
                                            state <= S_CSUM;
                                        end else begin
                                            idx <= idx + IONE;
                                        end
                                    end
                                endcase
                            end
                            S_CSUM: begin
                                if (s_data == csum) begin
                                    state   <= S_COMMIT;
                                    s_ready <= 1'b0;
                                    cload   <= 1'b1;
                                    caddr   <= a_base;
                                    cin     <= shadow[0];
                                    idx     <= '0;
                                end else begin
                                    state    <= S_IDLE;
                                    busy     <= 1'b0;
                                    err      <= 1'b1;
                                    err_code <= 2'd2;
                                end
                            end
                            default: begin
                                state <= S_IDLE;
                            end
                        endcase
                    end else if (tcnt == TLAST) begin
                        // Host stalled inside a frame: drop it rather than wait forever.
                        state    <= S_IDLE;
                        busy     <= 1'b0;
                        err      <= 1'b1;
                        err_code <= 2'd3;
                    end else begin
                        tcnt <= tcnt + TONE;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fir_coef_loader.sv
// tb/tb_fir_coef_loader.sv - randomized self-checking bench for fir_coef_loader
`timescale 1ns/1ps
module tb_fir_coef_loader;
    localparam int NTAPS   = 64;
    localparam int AW      = 6;
    localparam int CW      = 17;
    localparam int TIMEOUT = 1023;

    logic          clk_fast = 1'b0;
    logic          rst_n    = 1'b0;
    logic [7:0]    s_data   = 8'd0;
    logic          s_valid  = 1'b0;
    logic          s_ready;
    logic [CW-1:0] cin;
    logic [AW-1:0] caddr;
    logic          cload;
    logic          busy;
    logic          done;
    logic          err;
    logic [1:0]    err_code;

    always #5 clk_fast = ~clk_fast;

    fir_coef_loader #(.NTAPS(NTAPS), .AW(AW), .CW(CW), .TIMEOUT(TIMEOUT)) dut (
        .clk_fast (clk_fast),
        .rst_n    (rst_n),
        .s_data   (s_data),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .cin      (cin),
        .caddr    (caddr),
        .cload    (cload),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .err_code (err_code)
    );

    typedef struct {int cyc; int addr; int data;} wr_t;

    wr_t           wr_q[$];
    int            done_q[$];
    int            err_cyc_q[$];
    int            err_code_q[$];
    int            rdy_low    = 0;
    int            rdy_low_cl = 0;
    int            ecount     = 0;
    int            n_checks   = 0;
    int            n_fail     = 0;
    int            acc_edge   = 0;
    logic [7:0]    fr[$];
    logic [CW-1:0] m_coef   [NTAPS];
    logic [CW-1:0] exp_taps [NTAPS];
    logic [CW-1:0] fir_mem  [NTAPS];

    // ecount labels the cycle following each rising edge; sampled on the falling edge.
    always @(posedge clk_fast) ecount <= ecount + 1;

    always @(negedge clk_fast) begin
        if (cload) begin
            wr_q.push_back('{ecount, int'(caddr), int'(cin)});
            fir_mem[caddr] = cin;
        end
        if (done) done_q.push_back(ecount);
        if (err) begin
            err_cyc_q.push_back(ecount);
            err_code_q.push_back(int'(err_code));
        end
        if (!s_ready) rdy_low++;
        if (!s_ready && cload) rdy_low_cl++;
    end

    task automatic clear_mon();
        wr_q.delete();
        done_q.delete();
        err_cyc_q.delete();
        err_code_q.delete();
        rdy_low    = 0;
        rdy_low_cl = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk_fast);
        #1;
    endtask

    // Streams fr with s_valid held high; acc_edge is the edge that took the last byte.
    task automatic send_frame();
        @(negedge clk_fast);
        foreach (fr[i]) begin
            int w;
            w = 0;
            s_data  = fr[i];
            s_valid = 1'b1;
            while (!s_ready && w < 200) begin
                @(negedge clk_fast);
                w++;
            end
            if (w >= 200) begin
                n_fail++;
                $display("FAIL send_byte: s_ready stuck at %0b, required 1", s_ready);
            end
            acc_edge = ecount + 1;
            @(negedge clk_fast);
        end
        s_valid = 1'b0;
    endtask

    task automatic build_frame(input int n, input int a, input bit bad_csum);
        logic [7:0] x;
        logic [7:0] b;
        fr.delete();
        fr.push_back(8'hA5);
        fr.push_back(8'(n));
        fr.push_back(8'(a));
        x = 8'(n) ^ 8'(a);
        for (int k = 0; k < 3 * n; k++) begin
            b = 8'($urandom);
            fr.push_back(b);
            x ^= b;
        end
        fr.push_back(bad_csum ? ~x : x);
    endtask

    // Reference: parse fr by the frame rules. code 0 ok, 1 range, 2 checksum, 3 incomplete.
    task automatic model_frame(output int code, output int n, output int a);
        int p;
        int x;
        p = 0;
        code = 3;
        n = 0;
        a = 0;
        while (p < fr.size() && fr[p] != 8'hA5) p++;
        p++;
        if (p >= fr.size()) return;
        n = int'(fr[p]);
        x = n;
        p++;
        if (n == 0 || n > NTAPS) begin
            code = 1;
            return;
        end
        if (p >= fr.size()) return;
        a = int'(fr[p]);
        x ^= a;
        p++;
        if (a + n > NTAPS) begin
            code = 1;
            return;
        end
        for (int k = 0; k < n; k++) begin
            if (p + 2 >= fr.size()) return;
            m_coef[k] = {fr[p+2][0], fr[p+1], fr[p]};
            x ^= int'(fr[p]) ^ int'(fr[p+1]) ^ int'(fr[p+2]);
            p += 3;
        end
        if (p >= fr.size()) return;
        code = (int'(fr[p]) == x) ? 0 : 2;
    endtask

    task automatic test_reset();
        idle(3);
        n_checks++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL reset_s_ready: got %0b required 1", s_ready); end
        n_checks++; if (cin !== '0) begin n_fail++; $display("FAIL reset_cin: got %0h required 0", cin); end
        n_checks++; if (caddr !== '0) begin n_fail++; $display("FAIL reset_caddr: got %0h required 0", caddr); end
        n_checks++; if (cload !== 1'b0) begin n_fail++; $display("FAIL reset_cload: got %0b required 0", cload); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b required 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %0b required 0", done); end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %0b required 0", err); end
        n_checks++; if (err_code !== 2'd0) begin n_fail++; $display("FAIL reset_err_code: got %0d required 0", err_code); end
        @(negedge clk_fast);
        rst_n = 1'b1;
        idle(2);
    endtask

    task automatic test_directed();
        clear_mon();
        fr = '{8'hA5, 8'h02, 8'h00, 8'hCD, 8'hAB, 8'h01, 8'h01, 8'h00, 8'h00, 8'h64};
        send_frame();
        idle(6);
        n_checks++; if (wr_q.size() !== 2) begin n_fail++; $display("FAIL dir_nwr: got %0d required 2", wr_q.size()); end
        if (wr_q.size() == 2) begin
            n_checks++; if (wr_q[0].addr !== 0 || wr_q[0].data !== 32'h1ABCD || wr_q[0].cyc !== acc_edge) begin
                n_fail++; $display("FAIL dir_wr0: got a=%0d d=%0h c=%0d required a=0 d=1abcd c=%0d", wr_q[0].addr, wr_q[0].data, wr_q[0].cyc, acc_edge); end
            n_checks++; if (wr_q[1].addr !== 1 || wr_q[1].data !== 1 || wr_q[1].cyc !== acc_edge + 1) begin
                n_fail++; $display("FAIL dir_wr1: got a=%0d d=%0h c=%0d required a=1 d=1 c=%0d", wr_q[1].addr, wr_q[1].data, wr_q[1].cyc, acc_edge + 1); end
        end
        n_checks++; if (done_q.size() !== 1 || (done_q.size() == 1 && done_q[0] !== acc_edge + 2)) begin
            n_fail++; $display("FAIL dir_done: got %0d pulses required 1 at cycle %0d", done_q.size(), acc_edge + 2); end
        n_checks++; if (err_cyc_q.size() !== 0) begin n_fail++; $display("FAIL dir_err: got %0d pulses required 0", err_cyc_q.size()); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL dir_busy: got %0b required 0", busy); end
        exp_taps[0] = 17'h1ABCD;
        exp_taps[1] = 17'h00001;
    endtask

    task automatic test_range();
        for (int t = 0; t < 3; t++) begin
            clear_mon();
            case (t)
                0: fr = '{8'hA5, 8'h04, 8'h3E};
                1: fr = '{8'hA5, 8'h00};
                default: fr = '{8'hA5, 8'h41};
            endcase
            send_frame();
            n_checks++; if (busy !== 1'b0 || s_ready !== 1'b1) begin
                n_fail++; $display("FAIL range%0d_state: got busy=%0b s_ready=%0b required 0/1", t, busy, s_ready); end
            idle(4);
            n_checks++; if (err_cyc_q.size() !== 1 || (err_cyc_q.size() == 1 && (err_code_q[0] !== 1 || err_cyc_q[0] !== acc_edge))) begin
                n_fail++; $display("FAIL range%0d_err: got %0d pulses required 1 with code 1 at cycle %0d", t, err_cyc_q.size(), acc_edge); end
            n_checks++; if (wr_q.size() !== 0) begin n_fail++; $display("FAIL range%0d_cload: got %0d required 0", t, wr_q.size()); end
        end
    endtask

    task automatic test_csum();
        clear_mon();
        fr = '{8'hA5, 8'h02, 8'h00, 8'hCD, 8'hAB, 8'h01, 8'h01, 8'h00, 8'h00, 8'h65};
        send_frame();
        idle(6);
        n_checks++; if (err_cyc_q.size() !== 1 || (err_cyc_q.size() == 1 && (err_code_q[0] !== 2 || err_cyc_q[0] !== acc_edge))) begin
            n_fail++; $display("FAIL csum_err: got %0d pulses required 1 with code 2 at cycle %0d", err_cyc_q.size(), acc_edge); end
        n_checks++; if (wr_q.size() !== 0) begin n_fail++; $display("FAIL csum_cload: got %0d required 0", wr_q.size()); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL csum_busy: got %0b required 0", busy); end
        n_checks++; if (err_code !== 2'd2) begin n_fail++; $display("FAIL csum_err_code_hold: got %0d required 2", err_code); end
    endtask

    task automatic test_timeout();
        int w;
        clear_mon();
        fr = '{8'hA5, 8'h02};
        send_frame();
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL tmo_busy: got %0b required 1", busy); end
        w = 0;
        while (err_cyc_q.size() == 0 && w < TIMEOUT + 20) begin
            @(negedge clk_fast);
            w++;
        end
        idle(2);
        n_checks++; if (err_cyc_q.size() !== 1 || (err_cyc_q.size() == 1 && (err_code_q[0] !== 3 || err_cyc_q[0] !== acc_edge + TIMEOUT))) begin
            n_fail++; $display("FAIL tmo_err: got %0d pulses (first at %0d) required 1 with code 3 at cycle %0d", err_cyc_q.size(), (err_cyc_q.size() > 0) ? err_cyc_q[0] : -1, acc_edge + TIMEOUT); end
        clear_mon();
        fr = '{8'hA5, 8'h02, 8'h00, 8'hCD, 8'hAB, 8'h01, 8'h01, 8'h00, 8'h00, 8'h64};
        send_frame();
        idle(6);
        n_checks++; if (wr_q.size() !== 2 || done_q.size() !== 1 || err_cyc_q.size() !== 0) begin
            n_fail++; $display("FAIL tmo_recover: got wr=%0d done=%0d err=%0d required 2/1/0", wr_q.size(), done_q.size(), err_cyc_q.size()); end
    endtask

    task automatic test_back_to_back();
        int code, n, a;
        int bad;
        build_frame(NTAPS, 0, 1'b0);
        fr.push_front(8'h3C);
        fr.push_front(8'hFF);
        fr.push_front(8'h00);
        model_frame(code, n, a);
        clear_mon();
        send_frame();
        idle(NTAPS + 4);
        n_checks++; if (wr_q.size() !== NTAPS) begin n_fail++; $display("FAIL b2b_nwr: got %0d required %0d", wr_q.size(), NTAPS); end
        bad = 0;
        foreach (wr_q[k]) begin
            if (k < NTAPS && (wr_q[k].addr !== k || wr_q[k].data !== int'(m_coef[k]) || wr_q[k].cyc !== acc_edge + k)) bad++;
        end
        n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL b2b_writes: got %0d bad writes required 0", bad); end
        n_checks++; if (rdy_low !== NTAPS || rdy_low_cl !== NTAPS) begin
            n_fail++; $display("FAIL b2b_ready: got low=%0d low_with_cload=%0d required %0d", rdy_low, rdy_low_cl, NTAPS); end
        n_checks++; if (done_q.size() !== 1 || (done_q.size() == 1 && done_q[0] !== acc_edge + NTAPS)) begin
            n_fail++; $display("FAIL b2b_done: got %0d pulses required 1 at cycle %0d", done_q.size(), acc_edge + NTAPS); end
        if (code == 0) begin
            for (int k = 0; k < n; k++) exp_taps[a + k] = m_coef[k];
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 16; it++) begin
            int kind, n, a, code, mn, ma, bad;
            kind = $urandom_range(0, 3);
            if (kind <= 1) begin
                n = $urandom_range(1, NTAPS);
                a = $urandom_range(0, NTAPS - n);
                build_frame(n, a, 1'b0);
            end else if (kind == 2) begin
                n = $urandom_range(1, 8);
                a = $urandom_range(0, NTAPS - n);
                build_frame(n, a, 1'b1);
            end else if ($urandom_range(0, 1) == 0) begin
                n = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(NTAPS + 1, 255);
                fr = '{8'hA5, 8'(n)};
            end else begin
                n = $urandom_range(1, NTAPS);
                a = $urandom_range(NTAPS - n + 1, 255);
                fr = '{8'hA5, 8'(n), 8'(a)};
            end
            model_frame(code, mn, ma);
            clear_mon();
            send_frame();
            idle(NTAPS + 4);
            if (code == 0) begin
                bad = 0;
                foreach (wr_q[k]) begin
                    if (k < mn && (wr_q[k].addr !== ma + k || wr_q[k].data !== int'(m_coef[k]) || wr_q[k].cyc !== acc_edge + k)) bad++;
                end
                n_checks++; if (wr_q.size() !== mn || bad !== 0) begin
                    n_fail++; $display("FAIL rnd%0d_writes: got %0d writes (%0d bad) required %0d", it, wr_q.size(), bad, mn); end
                n_checks++; if (done_q.size() !== 1 || err_cyc_q.size() !== 0 || (done_q.size() == 1 && done_q[0] !== acc_edge + mn)) begin
                    n_fail++; $display("FAIL rnd%0d_done: got done=%0d err=%0d required one done at %0d", it, done_q.size(), err_cyc_q.size(), acc_edge + mn); end
                n_checks++; if (rdy_low !== mn) begin n_fail++; $display("FAIL rnd%0d_ready: got %0d low cycles required %0d", it, rdy_low, mn); end
                for (int k = 0; k < mn; k++) exp_taps[ma + k] = m_coef[k];
            end else begin
                n_checks++; if (err_cyc_q.size() !== 1 || (err_cyc_q.size() == 1 && (err_code_q[0] !== code || err_cyc_q[0] !== acc_edge))) begin
                    n_fail++; $display("FAIL rnd%0d_err: got %0d pulses required 1 with code %0d at cycle %0d", it, err_cyc_q.size(), code, acc_edge); end
                n_checks++; if (wr_q.size() !== 0 || done_q.size() !== 0) begin
                    n_fail++; $display("FAIL rnd%0d_noload: got wr=%0d done=%0d required 0/0", it, wr_q.size(), done_q.size()); end
            end
        end
    endtask

    task automatic test_reset_mid_commit();
        int code, n, a, bad;
        build_frame(NTAPS, 0, 1'b0);
        clear_mon();
        send_frame();
        repeat (9) @(posedge clk_fast);
        #2;
        n_checks++; if (cload !== 1'b1 || caddr !== AW'(9)) begin
            n_fail++; $display("FAIL rstc_pre: got cload=%0b caddr=%0d required 1/9", cload, caddr); end
        rst_n = 1'b0;
        #1;
        n_checks++; if (cload !== 1'b0 || busy !== 1'b0 || caddr !== '0 || cin !== '0 || s_ready !== 1'b1) begin
            n_fail++; $display("FAIL rstc_async: got cload=%0b busy=%0b caddr=%0d cin=%0h s_ready=%0b required 0/0/0/0/1", cload, busy, caddr, cin, s_ready); end
        @(negedge clk_fast);
        rst_n = 1'b1;
        idle(2);
        build_frame(NTAPS, 0, 1'b0);
        model_frame(code, n, a);
        clear_mon();
        send_frame();
        idle(NTAPS + 4);
        n_checks++; if (wr_q.size() !== NTAPS || done_q.size() !== 1 || err_cyc_q.size() !== 0) begin
            n_fail++; $display("FAIL rstc_fresh: got wr=%0d done=%0d err=%0d required %0d/1/0", wr_q.size(), done_q.size(), err_cyc_q.size(), NTAPS); end
        if (code == 0) begin
            for (int k = 0; k < n; k++) exp_taps[a + k] = m_coef[k];
        end
        bad = 0;
        for (int k = 0; k < NTAPS; k++) begin
            if (fir_mem[k] !== exp_taps[k]) bad++;
        end
        n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL tap_image: got %0d differing taps required 0", bad); end
    endtask

    initial begin
        for (int k = 0; k < NTAPS; k++) begin
            exp_taps[k] = '0;
            fir_mem[k]  = '0;
        end
        test_reset();
        test_directed();
        test_range();
        test_csum();
        test_timeout();
        test_back_to_back();
        test_random();
        test_reset_mid_commit();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/fir_coef_loader.md
# fir_coef_loader

Coefficient writer for the W4823 FIR tap memory. It accepts a framed byte stream from a host-side source, assembles 17-bit coefficients into an internal shadow buffer, and checks the frame. Only after the checksum passes does it stream the whole block into the FIR's `cin`/`caddr`/`cload` port, one tap per clock. It runs entirely in the fast-clock domain and sits between the host/UART byte path and the FIR coefficient port.

## Interface
- `NTAPS`, 64: number of FIR taps, i.e. tap-memory depth.
- `AW`, 6: address width; must satisfy 2^AW >= NTAPS.
- `CW`, 17: coefficient width.
- `TIMEOUT`, 1023: maximum idle cycles allowed between accepted bytes inside a frame.

- `clk_fast`  in  1  fast clock; all logic is on its rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `s_data`  in  8  host byte.
- `s_valid`  in  1  host byte valid.
- `s_ready`  out  1  loader can accept a byte; a byte transfers when `s_valid & s_ready` at a rising edge.
- `cin`  out  CW  coefficient to the FIR.
- `caddr`  out  AW  tap address to the FIR.
- `cload`  out  1  write strobe to the FIR, one tap per high cycle.
- `busy`  out  1  a frame or commit is in progress.
- `done`  out  1  one-cycle pulse after the last `cload` of a frame.
- `err`  out  1  one-cycle pulse when a frame is aborted.
- `err_code`  out  2  reason for the most recent abort: 1 range, 2 checksum, 3 timeout. Holds its value until the next abort.

## Operation
- Frame format: 0xA5 header, N (count byte), A (start address byte), N×3 data bytes, C (checksum byte).
  - Each coefficient is 3 bytes, LSB first: coef = {b2[0], b1, b0}.
  - b2[7:1] are ignored but are still included in the checksum.
- Checksum rule: XOR of N, A and all data bytes must equal C.
- State machine:
  - IDLE: `s_ready`=1. Bytes other than 0xA5 are dropped silently. 0xA5 → COUNT; `busy` goes to 1.
  - COUNT: latch N. If N==0 or N>NTAPS → abort code 1. Otherwise → ADDR.
  - ADDR: latch A. If A+N>NTAPS (compare in 8 bits, no wrap) → abort code 1. Otherwise → DATA.
  - DATA: byte index cycles 0,1,2. On the third byte, shadow[i] is written and i increments. After N coefficients → CSUM.
  - CSUM: compare the running XOR with C. Mismatch → abort code 2. Match → COMMIT.
  - COMMIT: `s_ready`=0. For i=0..N-1 on consecutive cycles: `cload`=1, `caddr`=A+i, `cin`=shadow[i]. Afterwards → IDLE with a `done` pulse; `busy` goes to 0.
- Abort behaviour:
  - `err` pulses and `err_code` is updated; state returns to IDLE with `busy`=0.
  - The shadow contents are discarded and no `cload` is issued, so the FIR taps are untouched.
  - A failed frame never partially writes the FIR.
- Timeout: in COUNT/ADDR/DATA/CSUM, a counter clears on each accepted byte and increments otherwise. When it reaches TIMEOUT → abort code 3.
- 0xA5 arriving mid-frame is treated as ordinary payload, not a resynchronisation.
- Outputs `cin`, `caddr` and `cload` are registered. `cin` and `caddr` hold their last values when `cload`=0.

## Timing
- Reset values: `s_ready`=1 (IDLE), `cin`=0, `caddr`=0, `cload`=0, `busy`=0, `done`=0, `err`=0, `err_code`=0.
- Byte accepted at edge k → the new state is visible after edge k.
- Validation aborts:
  - A range or checksum abort makes `err`=1 in the cycle after the offending byte is accepted.
  - `s_ready` stays 1 through that cycle; IDLE accepts the next byte.
- Timeout abort: `err` pulses TIMEOUT cycles after the last accepted byte.
- Commit:
  - Checksum byte accepted at edge k → `cload`=1 for cycles k+1 … k+N.
  - `done`=1 in cycle k+N+1; `busy` falls in that same cycle.
  - `s_ready`=0 for cycles k+1 … k+N.
- Minimum frame-to-write latency: checksum byte to first `cload` is 1 cycle.
- Back-pressure: only the loader deasserts ready, and only during COMMIT. `s_valid` gaps below TIMEOUT are legal.
- Reset asserted mid-frame or mid-commit: all outputs go to their reset values immediately (asynchronous), including `cload`=0. The partially loaded taps in the FIR are not rolled back.

## Test plan
- Bytes A5 02 00 CD AB 01 01 00 00 64:
  - `cload` is high for 2 cycles with (caddr 0, cin 0x1ABCD), then (caddr 1, cin 0x00001).
  - `done` pulses in the next cycle; `err` is never asserted.
- A5 04 3E → `err` pulse with code 1, no `cload`.
- A5 00 → `err` pulse with code 1.
- Same frame as the first scenario but with checksum byte 65 → `err` code 2, zero `cload` cycles, `busy` returns to 0.
- A5 02 followed by silence → `err` code 3 exactly TIMEOUT cycles after the 02 byte. A following valid frame then loads correctly.
- 00 FF 3C garbage, then a full 64-tap frame at A=0 with `s_valid` held high:
  - The garbage is ignored.
  - `cload` is high for 64 consecutive cycles with `caddr` 0…63, and `s_ready`=0 for exactly those cycles.
- Assert `rst_n` low during the 10th `cload` cycle → `cload`, `busy` and `caddr` are 0 immediately. After release the loader is in IDLE and a fresh frame is accepted.
